hist_accum: RTL

- Histogram accumulator directly upstream of the lock decision stage.
- Bins each incoming phase/amplitude sample into one of BOUND_NUM equal-width bins over a programmable window of samples, and tracks the peak bin while it accumulates.
- At window end, presents a registered snapshot of all bin counts (packed), the peak bin index and a one-cycle valid pulse. The lock stage consumes these as data_i / max_num_i / data_val_i.

---
 rtl/hist_accum_if.sv | 26 ++
 rtl/hist_accum.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hist_accum_if.sv
// hist_accum_if: sample input handshake and snapshot output bundle of the
// histogram accumulator. The slave modport is the accumulator side. The
// master modport is the producer/consumer side.
interface hist_accum_if #(
  parameter int SAMPLE_WIDTH    = 10,
  parameter int DATA_WIDTH      = 16,
  parameter int BOUND_NUM       = 32,
  parameter int BOUND_NUM_WIDTH = 5
);
  logic [SAMPLE_WIDTH-1:0]          sample_i;
  logic                             sample_val_i;
  logic                             sample_rdy_o;
  logic [DATA_WIDTH*BOUND_NUM-1:0]  data_o;
  logic [BOUND_NUM_WIDTH-1:0]       max_num_o;
  logic                             data_val_o;

  modport master (
    output sample_i, sample_val_i,
    input  sample_rdy_o, data_o, max_num_o, data_val_o
  );

  modport slave (
    input  sample_i, sample_val_i,
    output sample_rdy_o, data_o, max_num_o, data_val_o
  );
endinterface

// File: rtl/hist_accum.sv
// hist_accum: histogram accumulator feeding the lock decision stage.
// The block bins each sample by its top BOUND_NUM_WIDTH bits over a window of
// win_len_i samples and tracks the peak bin while the window fills. At window
// end it publishes a registered snapshot of all bins with a one-cycle valid
// pulse.
// Optional build macro HIST_SAT_FLAG_EN adds the sat_o output. sat_o goes to 1
// when some bin reached its saturation value during the published window.
module hist_accum #(
  parameter int SAMPLE_WIDTH    = 10,
  parameter int DATA_WIDTH      = 16,
  parameter int BOUND_NUM       = 32,
  parameter int BOUND_NUM_WIDTH = 5,
  parameter int WIN_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic [WIN_WIDTH-1:0] win_len_i,
  hist_accum_if.slave          bus
`ifdef HIST_SAT_FLAG_EN
  ,
  output logic                 sat_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SAT_VAL = {DATA_WIDTH{1'b1}};
  localparam logic [WIN_WIDTH-1:0]  WIN_ONE = {{(WIN_WIDTH-1){1'b0}}, 1'b1};

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [DATA_WIDTH-1:0]           r_bins [BOUND_NUM];
  logic [WIN_WIDTH-1:0]            r_win_len;
  logic [WIN_WIDTH-1:0]            r_cnt;
  logic [DATA_WIDTH-1:0]           r_max_val;
  logic [BOUND_NUM_WIDTH-1:0]      r_max_idx;
  logic                            r_rdy;
  logic                            r_data_val;
  logic [DATA_WIDTH*BOUND_NUM-1:0] r_data;
  logic [BOUND_NUM_WIDTH-1:0]      r_max_num;

  logic [BOUND_NUM_WIDTH-1:0]      w_idx;
  logic                            w_accept;
  logic [DATA_WIDTH:0]             w_inc;
  logic [DATA_WIDTH-1:0]           w_new;
  logic [WIN_WIDTH-1:0]            w_cnt_nxt;
  logic                            w_last;
  logic [WIN_WIDTH-1:0]            w_win_len_eff;

  // The bin index is the top bits of the sample. An accept needs enable, so an
  // enable drop in ACCUM aborts the window without counting that sample.
  assign w_idx         = bus.sample_i[SAMPLE_WIDTH-1 -: BOUND_NUM_WIDTH];
  assign w_accept      = (r_state == ACCUM) && enable_i && bus.sample_val_i && r_rdy;
  assign w_inc         = {1'b0, r_bins[w_idx]} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign w_new         = w_inc[DATA_WIDTH] ? SAT_VAL : w_inc[DATA_WIDTH-1:0];
  assign w_cnt_nxt     = r_cnt + WIN_ONE;
  assign w_last        = (w_cnt_nxt == r_win_len);
  assign w_win_len_eff = (win_len_i == {WIN_WIDTH{1'b0}}) ? WIN_ONE : win_len_i;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (enable_i) begin
          w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (!enable_i) begin
          w_state_nxt = CLEAR;
        end else if (w_accept && w_last) begin
          w_state_nxt = DUMP;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      DUMP: begin
        w_state_nxt = CLEAR;
      end
      CLEAR: begin
        if (enable_i) begin
          w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered ready: high for every cycle spent in ACCUM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= (w_state_nxt == ACCUM);
    end
  end

  // Bin counters: saturating increment on accept, zeroed outside a window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < BOUND_NUM; k++) begin
        r_bins[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_bins[w_idx] <= w_new;
          end
        end
        IDLE, CLEAR: begin
          for (int k = 0; k < BOUND_NUM; k++) begin
            r_bins[k] <= {DATA_WIDTH{1'b0}};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Window control and peak tracking. A strict greater-than keeps the first bin
  // that reached a tied count as the peak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_len <= WIN_ONE;
      r_cnt     <= {WIN_WIDTH{1'b0}};
      r_max_val <= {DATA_WIDTH{1'b0}};
      r_max_idx <= {BOUND_NUM_WIDTH{1'b0}};
    end else begin
      case (r_state)
        IDLE, CLEAR: begin
          r_cnt     <= {WIN_WIDTH{1'b0}};
          r_max_val <= {DATA_WIDTH{1'b0}};
          r_max_idx <= {BOUND_NUM_WIDTH{1'b0}};
          if (enable_i) begin
            r_win_len <= w_win_len_eff;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_new > r_max_val) begin
              r_max_val <= w_new;
              r_max_idx <= w_idx;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Snapshot registers. They load at DUMP and hold until the next DUMP.
  // The valid output pulses for the one cycle after DUMP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data     <= {(DATA_WIDTH*BOUND_NUM){1'b0}};
      r_max_num  <= {BOUND_NUM_WIDTH{1'b0}};
      r_data_val <= 1'b0;
    end else begin
      r_data_val <= (r_state == DUMP);
      if (r_state == DUMP) begin
        for (int k = 0; k < BOUND_NUM; k++) begin
          r_data[k*DATA_WIDTH +: DATA_WIDTH] <= r_bins[k];
        end
        r_max_num <= r_max_idx;
      end
    end
  end

`ifdef HIST_SAT_FLAG_EN
  logic r_sat_win;
  logic r_sat;

  // Saturation tracking: the flag is sticky within a window and is published
  // with the snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat_win <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, CLEAR: begin
          r_sat_win <= 1'b0;
        end
        ACCUM: begin
          if (w_accept && (w_new == SAT_VAL)) begin
            r_sat_win <= 1'b1;
          end
        end
        DUMP: begin
          r_sat <= r_sat_win;
        end
        default: begin
        end
      endcase
    end
  end

  assign sat_o = r_sat;
`endif

  assign bus.sample_rdy_o = r_rdy;
  assign bus.data_o       = r_data;
  assign bus.max_num_o    = r_max_num;
  assign bus.data_val_o   = r_data_val;

endmodule
